load_store_unit: RTL and testbench

//  Initiator for the word-addressed data memory port. Takes one load/store per handshake

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store initiator driving a word-addressed, byte-strobed memory port with a bounded ready wait.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats instead of reporting an error.
module load_store_unit #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

`ifdef LSU_MISALIGNED_EN
   typedef enum logic [1:0] {IDLE, ACC0, RESP, ACC1} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACC0, RESP} state_t;
`endif

   state_t        state;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [CW-1:0] tmo_cnt;

   logic [1:0]  off;
   logic [3:0]  mask, strb_lo;
   logic [31:0] data_lo, ld_word;
   logic [63:0] ld_pair;
   logic        illegal, bad;

   assign off = req_addr[1:0];

   always_comb begin
      case (req_funct3[1:0])
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
   end

   assign illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                    (req_we && req_funct3[2]);

`ifdef LSU_MISALIGNED_EN
   logic [3:0]  strb_hi, strb_hi_q;
   logic [31:0] data_hi, data_hi_q, rd0;
   assign {strb_hi, strb_lo} = {4'b0000, mask} << off;
   assign {data_hi, data_lo} = {32'h0, req_wdata} << {off, 3'b000};
   assign bad     = illegal;
   assign ld_pair = (state == ACC1) ? {mem_rdata, rd0} : {32'h0, mem_rdata};
`else
   assign strb_lo = mask << off;
   assign data_lo = req_wdata << {off, 3'b000};
   // without split support, any offset that is not a multiple of the access size is rejected
   assign bad     = illegal || (req_funct3[0] && off[0]) || (req_funct3[1] && (off != 2'b00));
   assign ld_pair = {32'h0, mem_rdata};
`endif

   assign ld_word = 32'(ld_pair >> {off_q, 3'b000});

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  extend = {{24{w[7]}}, w[7:0]};
         3'b001:  extend = {{16{w[15]}}, w[15:0]};
         3'b100:  extend = {24'h0, w[7:0]};
         3'b101:  extend = {16'h0, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wstrb  <= '0;
         mem_wdata  <= '0;
         tmo_cnt    <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
`ifdef LSU_MISALIGNED_EN
         strb_hi_q  <= '0;
         data_hi_q  <= '0;
         rd0        <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  off_q     <= off;
`ifdef LSU_MISALIGNED_EN
                  strb_hi_q <= strb_hi;
                  data_hi_q <= data_hi;
`endif
                  if (bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state     <= ACC0;
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= req_addr[ADDR_W-1:2];
                     mem_wstrb <= req_we ? strb_lo : 4'b0000;
                     mem_wdata <= req_we ? data_lo : 32'h0;
                     tmo_cnt   <= '0;
                  end
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               if (mem_ready) begin
`ifdef LSU_MISALIGNED_EN
                  rd0 <= mem_rdata;
                  if (state == ACC0 && strb_hi_q != 4'b0000) begin
                     // second beat of a word-crossing access; mem_valid stays high
                     state     <= ACC1;
                     mem_addr  <= mem_addr + 1'b1;
                     mem_wstrb <= we_q ? strb_hi_q : 4'b0000;
                     mem_wdata <= we_q ? data_hi_q : 32'h0;
                     tmo_cnt   <= '0;
                  end else
`endif
                  begin
                     state      <= RESP;
                     mem_valid  <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= we_q ? 32'h0 : extend(f3_q, ld_word);
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                     state      <= RESP;
                     mem_valid  <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: lane math, extension, wait states, timeout, errors, reset.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_ready, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request for a single cycle; returns 1ns into the cycle after acceptance.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic load_ok(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'h0);
      chk({tag, "_mvalid"}, 32'(mem_valid), 32'd1);
      chk({tag, "_maddr"}, 32'(mem_addr), addr >> 2);
      chk({tag, "_mwe"}, 32'(mem_we), 32'd0);
      chk({tag, "_mstrb"}, 32'(mem_wstrb), 32'd0);
      mem_ready = 1'b1;
      mem_rdata = word;
      tick();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp);
      chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
      chk({tag, "_mdrop"}, 32'(mem_valid), 32'd0);
      tick();
      chk({tag, "_rpulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic store_ok(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [31:0] lane_data);
      issue(1'b1, f3, addr, wdata);
      chk({tag, "_mvalid"}, 32'(mem_valid), 32'd1);
      chk({tag, "_mwe"}, 32'(mem_we), 32'd1);
      chk({tag, "_maddr"}, 32'(mem_addr), addr >> 2);
      chk({tag, "_mstrb"}, 32'(mem_wstrb), 32'(strb));
      chk({tag, "_mwdata"}, mem_wdata, lane_data);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_rerr"}, 32'(resp_err), 32'd0);
      tick();
   endtask

   task automatic reject(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
      issue(we, f3, addr, 32'hFFFF_FFFF);
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rerr"}, 32'(resp_err), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_nomem"}, 32'(mem_valid), 32'd0);
      tick();
      chk({tag, "_rpulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "_nomem2"}, 32'(mem_valid), 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      tick();

      load_ok("lw",  3'b010, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      chk("rdata_hold", resp_rdata, 32'hDEAD_BEEF);
      load_ok("lb",  3'b000, 32'h13, 32'h8012_3456, 32'hFFFF_FF80);
      load_ok("lbu", 3'b100, 32'h13, 32'h8012_3456, 32'h0000_0080);
      load_ok("lhu", 3'b101, 32'h12, 32'hABCD_0000, 32'h0000_ABCD);
      load_ok("lh",  3'b001, 32'h12, 32'h8001_1234, 32'hFFFF_8001);
      load_ok("lb0", 3'b000, 32'h04, 32'h0000_007F, 32'h0000_007F);

      store_ok("sb", 3'b000, 32'h21, 32'h0000_00A5, 4'b0010, 32'h0000_A500);
      store_ok("sh", 3'b001, 32'h22, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
      store_ok("sw", 3'b010, 32'h1C, 32'h1234_5678, 4'b1111, 32'h1234_5678);

      // wait states: outputs stay put until mem_ready
      issue(1'b0, 3'b010, 32'h30, 32'h0);
      chk("ws_busy_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("ws_mvalid", 32'(mem_valid), 32'd1);
         chk("ws_maddr", 32'(mem_addr), 32'hC);
         chk("ws_noresp", 32'(resp_valid), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ready = 1'b0;
      chk("ws_rvalid", 32'(resp_valid), 32'd1);
      chk("ws_rdata", resp_rdata, 32'h0BAD_F00D);
      tick();

      // timeout: mem_valid high for exactly TIMEOUT_CYC cycles
      issue(1'b0, 3'b010, 32'h40, 32'h0);
      n = 0;
      while (mem_valid && n < 40) begin
         n++;
         tick();
      end
      chk("tmo_cycles", 32'(n), 32'd16);
      chk("tmo_rvalid", 32'(resp_valid), 32'd1);
      chk("tmo_rerr", 32'(resp_err), 32'd1);
      chk("tmo_rdata", resp_rdata, 32'h0);
      tick();
      chk("tmo_ready", 32'(req_ready), 32'd1);

      reject("f3_011", 1'b0, 3'b011, 32'h10);
      reject("f3_110", 1'b0, 3'b110, 32'h10);
      reject("sbu",    1'b1, 3'b100, 32'h10);

`ifdef LSU_MISALIGNED_EN
      issue(1'b1, 3'b010, 32'h0E, 32'h1122_3344);
      chk("mis_a0_addr", 32'(mem_addr), 32'h3);
      chk("mis_a0_strb", 32'(mem_wstrb), 32'hC);
      chk("mis_a0_wdata", mem_wdata, 32'h3344_0000);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("mis_a1_valid", 32'(mem_valid), 32'd1);
      chk("mis_a1_addr", 32'(mem_addr), 32'h4);
      chk("mis_a1_strb", 32'(mem_wstrb), 32'h3);
      chk("mis_a1_wdata", mem_wdata, 32'h0000_1122);
      tick();
      chk("mis_a1_wait", 32'(mem_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("mis_rst_mvalid", 32'(mem_valid), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      chk("mis_rst_ready", 32'(req_ready), 32'd1);

      issue(1'b0, 3'b010, 32'h0E, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h5566_7788;
      tick();
      mem_rdata = 32'h1122_3344;
      chk("mis_ld_a1_addr", 32'(mem_addr), 32'h4);
      tick();
      mem_ready = 1'b0;
      chk("mis_ld_rvalid", 32'(resp_valid), 32'd1);
      chk("mis_ld_rdata", resp_rdata, 32'h3344_5566);
      tick();
`else
      reject("sw_mis", 1'b1, 3'b010, 32'h11);
      reject("sh_mis", 1'b1, 3'b001, 32'h21);
      reject("lh_mis", 1'b0, 3'b001, 32'h13);
`endif

      // asynchronous reset in the middle of an access
      issue(1'b0, 3'b010, 32'h50, 32'h0);
      chk("rst_mid_mvalid", 32'(mem_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_drop", 32'(mem_valid), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      #3 rst_n = 1'b1;
      tick();
      load_ok("post_rst", 3'b010, 32'h54, 32'hCAFE_F00D, 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
